// File: rtl/up_down_counter_mod_load.sv
// Modulo-MODULUS up/down counter with parallel load, wrap/saturate mode,
// combinational carry/borrow for cascading, and registered Zero/sticky Ovf flags.
module up_down_counter_mod_load #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Load,
    input  logic             Count,
    input  logic             Up,
    input  logic             Sat,
    output logic [WIDTH-1:0] A_count,
    output logic             C_out,
    output logic             Zero,
    output logic             Ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable for the load range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             zero_q;
    logic             ovf_q, ovf_d;
    logic             at_max, at_min, load_in_range;

    assign at_max        = (count_q == MAX_VAL);
    assign at_min        = (count_q == '0);
    assign load_in_range = ({1'b0, Data_in} < MOD_EXT);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (Load) begin
            count_d = load_in_range ? Data_in : MAX_VAL;
            ovf_d   = 1'b0;
        end else if (Count) begin
            if (Up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    if (!Sat) count_d = '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    ovf_d = 1'b1;
                    if (!Sat) count_d = MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            count_q <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
            ovf_q   <= ovf_d;
        end
    end

    assign A_count = count_q;
    assign Zero    = zero_q;
    assign Ovf     = ovf_q;
    assign C_out   = Count & ~Load & ((Up & at_max) | (~Up & at_min));

endmodule

// File: tb/tb_up_down_counter_mod_load.sv
// Directed bench for up_down_counter_mod_load: default 4-bit/16 instance and a
// 4-bit/10 instance sharing the same stimulus.
module tb_up_down_counter_mod_load;

    logic       CLK = 1'b0;
    logic       Clear_b;
    logic [3:0] Data_in;
    logic       Load, Count, Up, Sat;
    logic [3:0] A16, A10;
    logic       C16, C10, Z16, Z10, O16, O10;

    int checks = 0;
    int errors = 0;

    always #10 CLK = ~CLK;

    up_down_counter_mod_load dut16 (
        .CLK(CLK), .Clear_b(Clear_b), .Data_in(Data_in), .Load(Load),
        .Count(Count), .Up(Up), .Sat(Sat),
        .A_count(A16), .C_out(C16), .Zero(Z16), .Ovf(O16)
    );

    up_down_counter_mod_load #(.WIDTH(4), .MODULUS(10)) dut10 (
        .CLK(CLK), .Clear_b(Clear_b), .Data_in(Data_in), .Load(Load),
        .Count(Count), .Up(Up), .Sat(Sat),
        .A_count(A10), .C_out(C10), .Zero(Z10), .Ovf(O10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Clear_b = 1'b1; Data_in = 4'h0; Load = 1'b0; Count = 1'b0; Up = 1'b0; Sat = 1'b0;

        // Asynchronous clear before any clock edge
        #4 Clear_b = 1'b0;
        #1;
        chk("rst_A16", A16, 4'h0);
        chk("rst_Z16", Z16, 1'b1);
        chk("rst_O16", O16, 1'b0);
        chk("rst_A10", A10, 4'h0);
        #4 Clear_b = 1'b1;

        // Load A then count up with wrap
        Data_in = 4'hA; Load = 1'b1;
        cyc();
        chk("load_A16", A16, 4'hA);
        chk("load_Z16", Z16, 1'b0);
        chk("load_A10_clamp", A10, 4'h9);
        Load = 1'b0; Count = 1'b1; Up = 1'b1; Sat = 1'b0;
        #1 chk("cout_at_A", C16, 1'b0);
        for (int v = 11; v <= 15; v++) begin
            cyc();
            chk("up_A16", A16, 32'(v));
            chk("up_cout", C16, (v == 15) ? 1 : 0);
            chk("up_ovf_pre", O16, 1'b0);
        end
        cyc();
        chk("wrap_A16", A16, 4'h0);
        chk("wrap_Z16", Z16, 1'b1);
        chk("wrap_O16", O16, 1'b1);
        chk("wrap_cout", C16, 1'b0);

        // Load and count on the same edge; C_out gated by Load even at A=0 counting down
        Load = 1'b1; Data_in = 4'h3; Up = 1'b0;
        #1 chk("ldcnt_cout", C16, 1'b0);
        cyc();
        chk("ldcnt_A16", A16, 4'h3);
        chk("ldcnt_O16", O16, 1'b0);
        chk("ldcnt_Z16", Z16, 1'b0);

        // Saturating up to 15 then hold
        Load = 1'b0; Up = 1'b1; Sat = 1'b1;
        repeat (12) cyc();
        chk("sat_reach_A16", A16, 4'hF);
        chk("sat_reach_O16", O16, 1'b0);
        chk("sat_cout", C16, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sat_hold_A16", A16, 4'hF);
            chk("sat_hold_O16", O16, 1'b1);
        end
        Up = 1'b0;
        #1 chk("sat_dn_cout", C16, 1'b0);
        cyc();
        chk("sat_dn_A16", A16, 4'hE);
        chk("sat_dn_O16", O16, 1'b1);

        // Saturating down at 0
        Load = 1'b1; Data_in = 4'h0;
        cyc();
        chk("ld0_A16", A16, 4'h0);
        chk("ld0_O16", O16, 1'b0);
        Load = 1'b0;
        #1 chk("satlo_cout", C16, 1'b1);
        cyc();
        chk("satlo_A16", A16, 4'h0);
        chk("satlo_O16", O16, 1'b1);
        chk("satlo_Z16", Z16, 1'b1);

        // Hold with Count=0
        Count = 1'b0;
        cyc();
        chk("hold_A16", A16, 4'h0);
        chk("hold_O16", O16, 1'b1);

        // Count to 7, then clear between edges
        Count = 1'b1; Up = 1'b1; Sat = 1'b0;
        repeat (7) cyc();
        chk("pre_clr_A16", A16, 4'h7);
        chk("pre_clr_O16", O16, 1'b1);
        #2 Clear_b = 1'b0;
        #1;
        chk("midclr_A16", A16, 4'h0);
        chk("midclr_Z16", Z16, 1'b1);
        chk("midclr_O16", O16, 1'b0);
        #2 Clear_b = 1'b1;
        cyc();
        chk("postclr_A16", A16, 4'h1);
        chk("postclr_Z16", Z16, 1'b0);

        // Modulus-10 instance: count down from 0 with wrap
        Count = 1'b0;
        #2 Clear_b = 1'b0;
        #1 Clear_b = 1'b1;
        chk("m10_clr_A10", A10, 4'h0);
        Count = 1'b1; Up = 1'b0; Sat = 1'b0;
        #1 chk("m10_cout0", C10, 1'b1);
        cyc();
        chk("m10_wrap_A10", A10, 4'h9);
        chk("m10_wrap_O10", O10, 1'b1);
        for (int v = 8; v >= 0; v--) begin
            chk("m10_cout_mid", C10, 1'b0);
            cyc();
            chk("m10_dn_A10", A10, 32'(v));
        end
        chk("m10_cout_end", C10, 1'b1);
        chk("m10_Z10", Z10, 1'b1);

        Count = 1'b0; Load = 1'b1; Data_in = 4'hC;
        cyc();
        chk("m10_ldC_A10", A10, 4'h9);
        chk("m10_ldC_O10", O10, 1'b0);
        Load = 1'b0; Count = 1'b1; Up = 1'b1;
        #1 chk("m10_up_cout", C10, 1'b1);
        cyc();
        chk("m10_upwrap_A10", A10, 4'h0);
        chk("m10_upwrap_O10", O10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod_load.md
UP_DOWN_COUNTER_MOD_LOAD -- requirements
Module: up_down_counter_mod_load

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 Clear_b  input  1: reset, asynchronous, active-low; forces all state to reset values immediately.
REQ-005 Data_in  input  WIDTH: parallel-load value.
REQ-006 Load  input  1: synchronous parallel load, active-high.
REQ-007 Count  input  1: count enable, active-high.
REQ-008 Up  input  1: direction; 1 counts up, 0 counts down.
REQ-009 Sat  input  1: mode; 0 wraps at the range ends, 1 holds (saturates) at the range ends.
REQ-010 A_count  output  WIDTH: registered counter value.
REQ-011 C_out  output  1: combinational terminal-count/carry-borrow flag.
REQ-012 Zero  output  1: registered flag, 1 when A_count == 0.
REQ-013 Ovf  output  1: registered sticky flag for any wrap or saturation event since the last clear or load.

Function
REQ-014 Each rising edge applies the highest-priority active request: Load, then Count, then hold.
REQ-015 Load=1: A_count <= Data_in when Data_in < MODULUS; otherwise A_count <= MODULUS-1.
REQ-016 Load=1: Ovf <= 0, regardless of Count, Up and Sat.
REQ-017 Load=0, Count=1, Up=1, A_count < MODULUS-1: A_count <= A_count+1.
REQ-018 Load=0, Count=1, Up=1, A_count == MODULUS-1: A_count <= 0 if Sat=0, A_count holds if Sat=1; Ovf <= 1 in both modes.
REQ-019 Load=0, Count=1, Up=0, A_count > 0: A_count <= A_count-1.
REQ-020 Load=0, Count=1, Up=0, A_count == 0: A_count <= MODULUS-1 if Sat=0, A_count holds if Sat=1; Ovf <= 1 in both modes.
REQ-021 Load=0, Count=0: A_count and Ovf hold.
REQ-022 C_out = Count & ~Load & ((Up & A_count==MODULUS-1) | (~Up & A_count==0)), so a cascaded stage can advance on the same edge.
REQ-023 Zero tracks the next-state value, so it is valid in the same cycle as A_count.
REQ-024 Up and Sat are sampled on every edge; changing them between edges takes effect on the next edge with no extra latency.
REQ-025 All arithmetic is modulo MODULUS; A_count never leaves 0..MODULUS-1, including when MODULUS < 2**WIDTH.
REQ-026 Edge-to-output latency is one clock for A_count, Zero and Ovf; C_out is combinational, with zero latency.

Reset
REQ-027 Clear_b=0: A_count=0, Zero=1, Ovf=0 asynchronously, without waiting for CLK.
REQ-028 While Clear_b=0, Load and Count are ignored.
REQ-029 Release of Clear_b is synchronised by the user; the first active edge after release obeys REQ-014.
REQ-030 Clear_b asserted mid-count or mid-load discards the operation in progress; no partial update is retained.

Verification
REQ-031 Defaults; Clear_b pulse low at t=4..9 with CLK running -> A_count=0, Zero=1, Ovf=0 immediately at t=4, before any CLK edge.
REQ-032 Defaults; Data_in=4'hA, Load=1 for one edge, then Count=1, Up=1, Sat=0 -> A_count sequence A,B,C,D,E,F,0; C_out=1 only while A_count=F; Ovf=1 after the wrap to 0.
REQ-033 MODULUS=10, WIDTH=4; Count=1, Up=0, Sat=0 from 0 -> sequence 0,9,8..0; C_out=1 at A_count=0; Load with Data_in=4'hC -> A_count=9.
REQ-034 Sat=1, Up=1, count to MODULUS-1 and keep Count=1 for three more edges -> A_count holds at MODULUS-1, Ovf=1; switch Up=0 -> A_count decrements next edge, Ovf stays 1.
REQ-035 Load=1 and Count=1 on the same edge with Data_in=3 -> A_count=3, Ovf cleared, C_out=0.
REQ-036 Clear_b low between CLK edges while counting at A_count=7 -> A_count=0 immediately; on the first edge after release with Count=1, Up=1 -> A_count=1.
